// File: rtl/csr_arbiter.sv
// Two-requester (CU / PS) round-robin arbiter in front of a single CSR port, with burst cap and tagged read return.
// Optional CSR_ARB_STATS_EN adds saturating beat and conflict counters.
//
// state    | meaning
// IDLE     | no grant; picks a requester (round-robin when both ask)
// GRANT_CU | control unit owns the CSR port
// GRANT_PS | PS side owns the CSR port
module csr_arbiter #(
  parameter int DATA_WIDTH_CSR   = 8,
  parameter int ADDRESS_SIZE_CSR = 32,
  parameter int MAX_BURST        = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cu_req,
  input  logic                        cu_we,
  input  logic [ADDRESS_SIZE_CSR-1:0] cu_address,
  input  logic [DATA_WIDTH_CSR-1:0]   cu_wdata,
  output logic                        cu_gnt,
  output logic                        cu_rvalid,
  output logic [DATA_WIDTH_CSR-1:0]   cu_rdata,
  input  logic                        ps_req,
  input  logic                        ps_we,
  input  logic [ADDRESS_SIZE_CSR-1:0] ps_address,
  input  logic [DATA_WIDTH_CSR-1:0]   ps_wdata,
  output logic                        ps_gnt,
  output logic                        ps_rvalid,
  output logic [DATA_WIDTH_CSR-1:0]   ps_rdata,
`ifdef CSR_ARB_STATS_EN
  output logic [15:0]                 cu_beats,
  output logic [15:0]                 ps_beats,
  output logic [15:0]                 conflict_cnt,
`endif
  output logic                        csr_ce,
  output logic                        csr_we,
  output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
  output logic [DATA_WIDTH_CSR-1:0]   csr_din,
  input  logic [DATA_WIDTH_CSR-1:0]   csr_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT_CU, GRANT_PS} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             beat_cnt, beat_cnt_nxt;
  logic                      prefer_ps;
  logic                      acc_cu, acc_ps, acc;
  logic                      burst_done;
  logic                      bus_is_ps;
  logic [DATA_WIDTH_CSR-1:0] cu_rdata_q, ps_rdata_q;

  assign cu_gnt = (state == GRANT_CU);
  assign ps_gnt = (state == GRANT_PS);
  assign acc_cu = cu_gnt & cu_req;
  assign acc_ps = ps_gnt & ps_req;
  assign acc    = acc_cu | acc_ps;

  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (acc && (beat_cnt < CW'(MAX_BURST)))
      beat_cnt_nxt = beat_cnt + CW'(1);
  end

  assign burst_done = (beat_cnt_nxt == CW'(MAX_BURST));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cu_req && ps_req) state_nxt = prefer_ps ? GRANT_PS : GRANT_CU;
        else if (cu_req)      state_nxt = GRANT_CU;
        else if (ps_req)      state_nxt = GRANT_PS;
      end
      GRANT_CU: begin
        if (!cu_req)                  state_nxt = ps_req ? GRANT_PS : IDLE;
        else if (burst_done && ps_req) state_nxt = GRANT_PS;
      end
      GRANT_PS: begin
        if (!ps_req)                  state_nxt = cu_req ? GRANT_CU : IDLE;
        else if (burst_done && cu_req) state_nxt = GRANT_CU;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer remembers the last grant so the other side wins the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      prefer_ps <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= (state_nxt != state) ? '0 : beat_cnt_nxt;
      if (state_nxt != state && state_nxt == GRANT_CU)      prefer_ps <= 1'b1;
      else if (state_nxt != state && state_nxt == GRANT_PS) prefer_ps <= 1'b0;
    end
  end

  // Address/data hold their last beat when idle; only ce/we drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_ce      <= 1'b0;
      csr_we      <= 1'b0;
      csr_address <= '0;
      csr_din     <= '0;
      bus_is_ps   <= 1'b0;
      cu_rvalid   <= 1'b0;
      ps_rvalid   <= 1'b0;
      cu_rdata_q  <= '0;
      ps_rdata_q  <= '0;
    end else begin
      csr_ce    <= acc;
      csr_we    <= acc_cu ? cu_we : (acc_ps ? ps_we : 1'b0);
      bus_is_ps <= acc_ps;
      if (acc_cu) begin
        csr_address <= cu_address;
        csr_din     <= cu_wdata;
      end else if (acc_ps) begin
        csr_address <= ps_address;
        csr_din     <= ps_wdata;
      end
      cu_rvalid <= csr_ce & ~csr_we & ~bus_is_ps;
      ps_rvalid <= csr_ce & ~csr_we & bus_is_ps;
      if (cu_rvalid) cu_rdata_q <= csr_dout;
      if (ps_rvalid) ps_rdata_q <= csr_dout;
    end
  end

  // Read data is passed straight through in the return cycle, then held.
  assign cu_rdata = cu_rvalid ? csr_dout : cu_rdata_q;
  assign ps_rdata = ps_rvalid ? csr_dout : ps_rdata_q;

`ifdef CSR_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cu_beats     <= '0;
      ps_beats     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (acc_cu && cu_beats != 16'hFFFF)                 cu_beats     <= cu_beats + 16'd1;
      if (acc_ps && ps_beats != 16'hFFFF)                 ps_beats     <= ps_beats + 16'd1;
      if (cu_req && ps_req && conflict_cnt != 16'hFFFF)   conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_arbiter.sv
// Self-checking bench for csr_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
// Stats checks are compiled in only when CSR_ARB_STATS_EN is defined.
module tb_csr_arbiter;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cu_req, cu_we, ps_req, ps_we;
  logic [AW-1:0] cu_address, ps_address;
  logic [DW-1:0] cu_wdata, ps_wdata;
  logic          cu_gnt, cu_rvalid, ps_gnt, ps_rvalid;
  logic [DW-1:0] cu_rdata, ps_rdata;
  logic          csr_ce, csr_we;
  logic [AW-1:0] csr_address;
  logic [DW-1:0] csr_din, csr_dout;
`ifdef CSR_ARB_STATS_EN
  logic [15:0]   cu_beats, ps_beats, conflict_cnt;
`endif

  always #5 clk = ~clk;

  csr_arbiter #(.DATA_WIDTH_CSR(DW), .ADDRESS_SIZE_CSR(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cu_req(cu_req), .cu_we(cu_we), .cu_address(cu_address), .cu_wdata(cu_wdata),
    .cu_gnt(cu_gnt), .cu_rvalid(cu_rvalid), .cu_rdata(cu_rdata),
    .ps_req(ps_req), .ps_we(ps_we), .ps_address(ps_address), .ps_wdata(ps_wdata),
    .ps_gnt(ps_gnt), .ps_rvalid(ps_rvalid), .ps_rdata(ps_rdata),
`ifdef CSR_ARB_STATS_EN
    .cu_beats(cu_beats), .ps_beats(ps_beats), .conflict_cnt(conflict_cnt),
`endif
    .csr_ce(csr_ce), .csr_we(csr_we), .csr_address(csr_address), .csr_din(csr_din),
    .csr_dout(csr_dout)
  );

  typedef struct packed {
    logic          cu_gnt, ps_gnt, ce, we, cu_rv, ps_rv;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, cu_rd, ps_rd;
  } snap_t;

  snap_t obs, exp_s;
  logic [DW-1:0] s_dout;
  int n_cmp = 0, n_fail = 0, cyc = 0;

  // Reference model: owner 0 = nobody, 1 = CU, 2 = PS.
  int            m_owner, m_beats, m_prefer, m_s1, m_s2;
  bit            m_ce, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_rd_cu, m_rd_ps;
  int            m_cub, m_psb, m_conf;

  function automatic snap_t snap();
    snap_t s;
    s.cu_gnt = cu_gnt; s.ps_gnt = ps_gnt; s.ce = csr_ce; s.we = csr_we;
    s.cu_rv = cu_rvalid; s.ps_rv = ps_rvalid; s.addr = csr_address;
    s.din = csr_din; s.cu_rd = cu_rdata; s.ps_rd = ps_rdata;
    return s;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_prefer = 1; m_s1 = 0; m_s2 = 0;
    m_ce = 0; m_we = 0; m_addr = '0; m_din = '0; m_rd_cu = '0; m_rd_ps = '0;
    m_cub = 0; m_psb = 0; m_conf = 0; cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cu_req = 0; cu_we = 0; cu_address = '0; cu_wdata = '0;
    ps_req = 0; ps_we = 0; ps_address = '0; ps_wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, snapshot DUT and model, advance model, move to next cycle.
  task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit pr, input bit pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
    bit rv_cu, rv_ps;
    bit rq[3];
    int a, nxt, bts, o;
    cu_req = cr; cu_we = cw; cu_address = ca; cu_wdata = cd;
    ps_req = pr; ps_we = pw; ps_address = pa; ps_wdata = pd;
    s_dout = DW'($urandom);
    csr_dout = s_dout;
    #1;
    rv_cu = (m_s2 == 1);
    rv_ps = (m_s2 == 2);
    exp_s.cu_gnt = (m_owner == 1); exp_s.ps_gnt = (m_owner == 2);
    exp_s.ce = m_ce; exp_s.we = m_we; exp_s.cu_rv = rv_cu; exp_s.ps_rv = rv_ps;
    exp_s.addr = m_addr; exp_s.din = m_din;
    exp_s.cu_rd = rv_cu ? s_dout : m_rd_cu;
    exp_s.ps_rd = rv_ps ? s_dout : m_rd_ps;
    obs = snap();
    if (rv_cu) m_rd_cu = s_dout;
    if (rv_ps) m_rd_ps = s_dout;
    rq[0] = 0; rq[1] = cr; rq[2] = pr;
    a = (m_owner != 0 && rq[m_owner]) ? m_owner : 0;
    m_s2 = m_s1;
    m_s1 = (a == 1 && !cw) ? 1 : ((a == 2 && !pw) ? 2 : 0);
    m_ce = (a != 0);
    m_we = (a == 1) ? cw : ((a == 2) ? pw : 1'b0);
    if (a == 1) begin m_addr = ca; m_din = cd; end
    else if (a == 2) begin m_addr = pa; m_din = pd; end
    if (a == 1) m_cub++;
    if (a == 2) m_psb++;
    if (cr && pr) m_conf++;
    bts = m_beats + ((a != 0) ? 1 : 0);
    if (bts > MB) bts = MB;
    if (m_owner == 0) nxt = (cr && pr) ? m_prefer : (cr ? 1 : (pr ? 2 : 0));
    else begin
      o = 3 - m_owner;
      if (!rq[m_owner])         nxt = rq[o] ? o : 0;
      else if (bts >= MB && rq[o]) nxt = o;
      else                      nxt = m_owner;
    end
    if (nxt != m_owner) begin
      bts = 0;
      if (nxt != 0) m_prefer = 3 - nxt;
    end
    m_beats = bts; m_owner = nxt;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cu_req = 1; cu_we = 0; cu_address = 32'h55; cu_wdata = 8'h12;
    ps_req = 1; ps_we = 1; ps_address = 32'h66; ps_wdata = 8'h34;
    csr_dout = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    obs = snap();
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    reset = 1'b0;
    model_reset();
    step(1, 0, 32'h55, 8'h12, 1, 1, 32'h66, 8'h34);
    n_cmp++;
    if ({obs.cu_gnt, obs.ps_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_first_cycle_idle got=%b exp=00", {obs.cu_gnt, obs.ps_gnt});
    end
    step(1, 0, 32'h55, 8'h12, 1, 1, 32'h66, 8'h34);
    n_cmp++;
    if ({obs.cu_gnt, obs.ps_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL reset_cu_wins_tie got=%b exp=10", {obs.cu_gnt, obs.ps_gnt});
    end
    n_cmp++;
    if (obs !== exp_s) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", obs, exp_s); end
  endtask

  task automatic test_single_read();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(i < 2, 0, 32'h4, 8'h00, 0, 0, 32'h0, 8'h00);
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL single_read_model cyc=%0d got=%h exp=%h", i, obs, exp_s); end
      if (i == 1) begin
        n_cmp++;
        if (obs.cu_gnt !== 1'b1) begin n_fail++; $display("FAIL single_read_gnt got=%b exp=1", obs.cu_gnt); end
      end
      if (i == 2) begin
        n_cmp++;
        if ({obs.ce, obs.we, obs.addr} !== {2'b10, 32'h4}) begin
          n_fail++; $display("FAIL single_read_bus got=%b/%b/%h exp=1/0/4", obs.ce, obs.we, obs.addr);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({obs.cu_rv, obs.ps_rv, obs.cu_rd} !== {2'b10, s_dout}) begin
          n_fail++; $display("FAIL single_read_rvalid got=%b/%b/%h exp=1/0/%h", obs.cu_rv, obs.ps_rv, obs.cu_rd, s_dout);
        end
      end
    end
  endtask

  task automatic test_rr_burst();
    logic [1:0] g;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 1'($urandom), $urandom, DW'($urandom), 1, 1'($urandom), $urandom, DW'($urandom));
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, obs, exp_s); end
      if (i == 0)                    g = 2'b00;
      else if (((i - 1) / 4) % 2 == 0) g = 2'b10;
      else                           g = 2'b01;
      n_cmp++;
      if ({obs.cu_gnt, obs.ps_gnt} !== g) begin
        n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, {obs.cu_gnt, obs.ps_gnt}, g);
      end
    end
  endtask

  task automatic test_preempt();
    logic [1:0] g;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i >= 2, 0, $urandom, DW'($urandom), 1, 1, $urandom, DW'($urandom));
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL preempt_model cyc=%0d got=%h exp=%h", i, obs, exp_s); end
      g = (i == 0) ? 2'b00 : ((i <= 4) ? 2'b01 : 2'b10);
      n_cmp++;
      if ({obs.cu_gnt, obs.ps_gnt} !== g) begin
        n_fail++; $display("FAIL preempt_grant cyc=%0d got=%b exp=%b", i, {obs.cu_gnt, obs.ps_gnt}, g);
      end
    end
  endtask

  task automatic test_handover_read();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(i <= 4, i != 4, (i == 4) ? 32'h10 : $urandom, DW'($urandom),
           (i >= 1 && i <= 6), 0, $urandom, DW'($urandom));
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL handover_model cyc=%0d got=%h exp=%h", i, obs, exp_s); end
      if (i == 5) begin
        n_cmp++;
        if ({obs.ps_gnt, obs.ce, obs.we, obs.addr} !== {3'b110, 32'h10}) begin
          n_fail++; $display("FAIL handover_bus got=%b/%b/%b/%h exp=1/1/0/10", obs.ps_gnt, obs.ce, obs.we, obs.addr);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({obs.cu_rv, obs.ps_rv, obs.cu_rd} !== {2'b10, s_dout}) begin
          n_fail++; $display("FAIL handover_route got=%b/%b/%h exp=1/0/%h", obs.cu_rv, obs.ps_rv, obs.cu_rd, s_dout);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, $urandom, DW'($urandom), 0, 0, '0, '0);
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL midrst_pre cyc=%0d got=%h exp=%h", i, obs, exp_s); end
    end
    reset = 1'b1;
    #1;
    obs = snap();
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL midrst_async got=%h exp=0", obs); end
    cu_req = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 0, 0, '0, '0);
      n_cmp++;
      if ({obs.cu_rv, obs.ps_rv, obs.ce} !== 3'b000) begin
        n_fail++; $display("FAIL midrst_stale cyc=%0d got=%b exp=000", i, {obs.cu_rv, obs.ps_rv, obs.ce});
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(i < 2, 0, $urandom, DW'($urandom), 0, 0, '0, '0);
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL midrst_post cyc=%0d got=%h exp=%h", i, obs, exp_s); end
      if (i == 1) begin
        n_cmp++;
        if (obs.cu_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_regrant got=%b exp=1", obs.cu_gnt); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 6, 1'($urandom), $urandom, DW'($urandom),
           $urandom_range(0, 9) < 5, 1'($urandom), $urandom, DW'($urandom));
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, exp_s); end
      n_cmp++;
      if (obs.cu_gnt && obs.ps_gnt) begin n_fail++; $display("FAIL random_dual_grant cyc=%0d got=11 exp=not 11", i); end
    end
  endtask

`ifdef CSR_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(i <= 6, 1, $urandom, DW'($urandom), (i >= 5 && i <= 8), 0, $urandom, DW'($urandom));
      n_cmp++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL stats_model cyc=%0d got=%h exp=%h", i, obs, exp_s); end
    end
    n_cmp++;
    if ({cu_beats, ps_beats, conflict_cnt} !== {16'd5, 16'd3, 16'd2}) begin
      n_fail++; $display("FAIL stats_counts got=%0d/%0d/%0d exp=5/3/2", cu_beats, ps_beats, conflict_cnt);
    end
    n_cmp++;
    if ({cu_beats, ps_beats, conflict_cnt} !== {16'(m_cub), 16'(m_psb), 16'(m_conf)}) begin
      n_fail++; $display("FAIL stats_vs_model got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         cu_beats, ps_beats, conflict_cnt, m_cub, m_psb, m_conf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_rr_burst();
    test_preempt();
    test_handover_read();
    test_reset_mid_burst();
    test_random();
`ifdef CSR_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
